// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8-entry register file with write-back bypass and a
// single registered output slot (op_a / op_b / op_imm / op_sel) behind a
// valid/ready handshake on both sides.
module operand_fetch #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs_a,
    input  logic [ADDR_W-1:0] rs_b,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] op_imm,
    output logic              op_sel
);

    localparam int unsigned NREG = 1 << ADDR_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] regs [NREG];

    // The slot can take a new instruction when empty or when it drains this cycle
    assign in_ready  = (state == EMPTY) || out_ready;
    assign out_valid = (state == FULL);

    // Source reads: r0 is hard zero, a same-cycle write-back is forwarded
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (rs_a != '0) begin
            rd_a = (wr_en && (wr_addr == rs_a)) ? wr_data : regs[rs_a];
        end
        if (rs_b != '0) begin
            rd_b = (wr_en && (wr_addr == rs_b)) ? wr_data : regs[rs_b];
        end
    end

    // Next-state logic for the single-entry output slot
    always_comb begin
        state_next = state;
        accept     = in_valid && in_ready;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (out_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Register file write port; r0 writes are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Output slot: snapshot of the operands at accept, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            op_imm <= '0;
            op_sel <= 1'b0;
        end else if (accept) begin
            op_a   <= rd_a;
            op_b   <= rd_b;
            op_imm <= imm;
            op_sel <= use_imm;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: table of stimulus rows with the
// expected operands of each accepted instruction, fed through a scoreboard
// queue and compared whenever the output slot is valid.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  rs_a;
    logic [2:0]  rs_b;
    logic [15:0] imm;
    logic        use_imm;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] op_imm;
    logic        op_sel;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs_a(rs_a), .rs_b(rs_b), .imm(imm), .use_imm(use_imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .op_imm(op_imm), .op_sel(op_sel)
    );

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_addr;
        logic [15:0] wr_data;
        logic        in_valid;
        logic [2:0]  rs_a;
        logic [2:0]  rs_b;
        logic [15:0] imm;
        logic        use_imm;
        logic        out_ready;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic        sel;
    } slot_t;

    slot_t sbq[$];
    vec_t  tbl[17];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    valid_cycles = 0;
    logic  m_valid = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check the slot against the scoreboard, advance the clock
    task automatic apply(input vec_t v);
        logic acc;
        slot_t s;
        wr_en     = v.wr_en;
        wr_addr   = v.wr_addr;
        wr_data   = v.wr_data;
        in_valid  = v.in_valid;
        rs_a      = v.rs_a;
        rs_b      = v.rs_b;
        imm       = v.imm;
        use_imm   = v.use_imm;
        out_ready = v.out_ready;
        #1;
        check("in_ready", 16'(in_ready), 16'(!m_valid || v.out_ready));
        check("out_valid", 16'(out_valid), 16'(m_valid));
        if (out_valid) valid_cycles++;
        if (m_valid) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got slot valid expected no pending entry at %0t", $time);
            end else begin
                s = sbq[0];
                check("op_a", op_a, s.a);
                check("op_b", op_b, s.b);
                check("op_imm", op_imm, s.imm);
                check("op_sel", 16'(op_sel), 16'(s.sel));
                if (v.out_ready) void'(sbq.pop_front());
            end
        end
        acc = v.in_valid && (!m_valid || v.out_ready);
        if (acc) sbq.push_back('{v.exp_a, v.exp_b, v.imm, v.use_imm});
        m_valid = acc ? 1'b1 : (v.out_ready ? 1'b0 : m_valid);
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge while also presenting a write and an instruction that must be ignored
    task automatic do_reset();
        rst      = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 3'd5;
        wr_data  = 16'hAAAA;
        in_valid = 1'b1;
        rs_a     = 3'd1;
        rs_b     = 3'd2;
        imm      = 16'h5A5A;
        use_imm  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_en    = 1'b0;
        in_valid = 1'b0;
        m_valid  = 1'b0;
        sbq.delete();
        #1;
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_in_ready", 16'(in_ready), 16'h1);
        check("rst_op_a", op_a, 16'h0);
        check("rst_op_b", op_b, 16'h0);
        check("rst_op_imm", op_imm, 16'h0);
        check("rst_op_sel", 16'(op_sel), 16'h0);
    endtask

    function automatic vec_t rd(input logic [2:0] a, input logic [2:0] b,
                                input logic [15:0] ea, input logic [15:0] eb);
        rd = '{1'b0, 3'd0, 16'h0, 1'b1, a, b, 16'h0, 1'b0, 1'b1, ea, eb};
    endfunction

    function automatic vec_t wr(input logic [2:0] a, input logic [15:0] d);
        wr = '{1'b1, a, d, 1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0};
    endfunction

    function automatic logic [15:0] burst_val(input int r);
        burst_val = 16'(r * 16'h1111);
    endfunction

    initial begin
        vec_t v;
        int vc0;
        rst = 1'b1; in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
        rs_a = '0; rs_b = '0; imm = '0; use_imm = 1'b0; wr_addr = '0; wr_data = '0;
        @(posedge clk);
        #1;
        do_reset();

        //          wr  wa    wdata      iv  ra    rb    imm        ui  ordy exp_a      exp_b
        tbl[0]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd0, 16'h0055, 1'b0, 1'b1, 16'h1234, 16'h0000};
        tbl[3]  = '{1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[5]  = '{1'b1, 3'd4, 16'hBEEF, 1'b1, 3'd4, 3'd4, 16'h0007, 1'b1, 1'b1, 16'hBEEF, 16'hBEEF};
        tbl[6]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd2, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'h1234};
        tbl[7]  = '{1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 16'h0001, 1'b1, 1'b1, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b1, 3'd1, 16'h0011, 1'b0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[9]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd3, 16'h00A5, 1'b0, 1'b0, 16'h0011, 16'h0000};
        tbl[10] = '{1'b1, 3'd1, 16'h0022, 1'b1, 3'd1, 3'd1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[11] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[12] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[13] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};
        tbl[14] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd1, 16'hC0DE, 1'b1, 1'b1, 16'h0022, 16'h0022};
        tbl[15] = '{1'b1, 3'd6, 16'h6666, 1'b1, 3'd2, 3'd6, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'h6666};
        tbl[16] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};

        foreach (tbl[i]) apply(tbl[i]);

        // Back-to-back burst: load r1..r7, then 8 accepts with no bubbles
        for (int r = 1; r < 8; r++) apply(wr(3'(r), burst_val(r)));
        vc0 = valid_cycles;
        for (int i = 0; i < 8; i++) begin
            apply(rd(3'(i), 3'((i + 3) % 8), burst_val(i), burst_val((i + 3) % 8)));
        end
        apply(rd(3'd0, 3'd0, 16'h0, 16'h0));
        check("burst_valid_cycles", 16'(valid_cycles - vc0), 16'd8);
        v = rd(3'd0, 3'd0, 16'h0, 16'h0);
        v.in_valid = 1'b0;
        apply(v);

        // Reset in the middle of a stall drops the held instruction and clears every register
        v = rd(3'd7, 3'd6, burst_val(7), burst_val(6));
        v.out_ready = 1'b0;
        apply(v);
        v.in_valid = 1'b0;
        apply(v);
        do_reset();
        for (int r = 0; r < 8; r++) apply(rd(3'(r), 3'(r), 16'h0, 16'h0));
        v = rd(3'd0, 3'd0, 16'h0, 16'h0);
        v.in_valid = 1'b0;
        apply(v);
        apply(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
